// File: rtl/div_arbiter_2ch.sv
// div_arbiter_2ch
// Round-robin arbiter that shares one signed Start/Done divider between two
// requesters. Only one division is in flight at a time. The block captures the
// granted operands and pulses Div_Start. It returns the divider results to the
// owning channel. It intercepts divide-by-zero locally and aborts an operation
// whose divider never answers.
//
// state  | meaning
// -------+-----------------------------------------------------------------
// IDLE   | no operation in flight; arbitrate and capture operands
// ISSUE  | one cycle: Ack the granted channel, start divider or flag den==0
// WAIT   | divider busy; wait for Div_Done or the timeout to expire
module div_arbiter_2ch #(
    parameter int tamanyo = 32,
    parameter int TIMEOUT = 128
) (
    input  logic               CLK,
    input  logic               RSTa,
    input  logic               Req0,
    input  logic               Req1,
    input  logic [tamanyo-1:0] Num0,
    input  logic [tamanyo-1:0] Den0,
    input  logic [tamanyo-1:0] Num1,
    input  logic [tamanyo-1:0] Den1,
    output logic               Ack0,
    output logic               Ack1,
    output logic               Vld0,
    output logic               Vld1,
    output logic               Err0,
    output logic               Err1,
    output logic [tamanyo-1:0] Coc0,
    output logic [tamanyo-1:0] Res0,
    output logic [tamanyo-1:0] Coc1,
    output logic [tamanyo-1:0] Res1,
    output logic               Div_Start,
    output logic [tamanyo-1:0] Div_Num,
    output logic [tamanyo-1:0] Div_Den,
    input  logic [tamanyo-1:0] Div_Coc,
    input  logic [tamanyo-1:0] Div_Res,
    input  logic               Div_Done
);

    // Counter holds cycles elapsed since Div_Start, so it must reach TIMEOUT-1.
    localparam int CW = $clog2(TIMEOUT) + 1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2
    } state_t;

    state_t             state;
    state_t             state_nxt;
    logic               g;          // channel owning the current operation
    logic               last;       // channel served most recently
    logic               grant_id;
    logic [CW-1:0]      cnt;
    logic               den_zero;
    logic               tmo_hit;
    logic               fin;
    logic               fin_err;
    logic [tamanyo-1:0] fin_coc;
    logic [tamanyo-1:0] fin_res;

    assign den_zero = (Div_Den == '0);
    assign tmo_hit  = (state == S_WAIT) && (cnt == CW'(TIMEOUT - 1));

    // State register.
    always_ff @(posedge CLK) begin
        if (RSTa) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state, arbitration, handshake strobes and result selection.
    always_comb begin
        state_nxt = state;
        grant_id  = g;
        Ack0      = 1'b0;
        Ack1      = 1'b0;
        Div_Start = 1'b0;
        fin       = 1'b0;
        fin_err   = 1'b0;
        fin_coc   = '0;
        fin_res   = '0;
        case (state)
            S_IDLE: begin
                if (Req0 || Req1) begin
                    state_nxt = S_ISSUE;
                    // On a tie the channel not served last wins.
                    grant_id  = (Req0 && Req1) ? ~last : Req1;
                end
            end
            S_ISSUE: begin
                Ack0 = ~g;
                Ack1 = g;
                if (den_zero) begin
                    // The divider is never started for a zero divisor.
                    fin       = 1'b1;
                    fin_err   = 1'b1;
                    fin_coc   = '1;
                    fin_res   = Div_Num;
                    state_nxt = S_IDLE;
                end else begin
                    Div_Start = 1'b1;
                    state_nxt = S_WAIT;
                end
            end
            S_WAIT: begin
                // Div_Done takes priority over a timeout in the same cycle.
                if (Div_Done) begin
                    fin       = 1'b1;
                    fin_coc   = Div_Coc;
                    fin_res   = Div_Res;
                    state_nxt = S_IDLE;
                end else if (tmo_hit) begin
                    fin       = 1'b1;
                    fin_err   = 1'b1;
                    state_nxt = S_IDLE;
                end
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    // Grant capture, operand registers and round-robin pointer.
    always_ff @(posedge CLK) begin
        if (RSTa) begin
            g       <= 1'b0;
            last    <= 1'b1;
            Div_Num <= '0;
            Div_Den <= '0;
        end else begin
            if (state == S_IDLE && (Req0 || Req1)) begin
                g       <= grant_id;
                Div_Num <= grant_id ? Num1 : Num0;
                Div_Den <= grant_id ? Den1 : Den0;
            end
            if (state == S_ISSUE) begin
                last <= g;
            end
        end
    end

    // Timeout counter: 1 in the first WAIT cycle, counting cycles since Div_Start.
    always_ff @(posedge CLK) begin
        if (RSTa) begin
            cnt <= '0;
        end else if (state == S_ISSUE) begin
            cnt <= CW'(1);
        end else if (state == S_WAIT) begin
            cnt <= cnt + CW'(1);
        end
    end

    // Per-channel result registers; Vld pulses one cycle after completion.
    always_ff @(posedge CLK) begin
        if (RSTa) begin
            Vld0 <= 1'b0;
            Vld1 <= 1'b0;
            Err0 <= 1'b0;
            Err1 <= 1'b0;
            Coc0 <= '0;
            Res0 <= '0;
            Coc1 <= '0;
            Res1 <= '0;
        end else begin
            Vld0 <= 1'b0;
            Vld1 <= 1'b0;
            if (fin) begin
                if (g) begin
                    Vld1 <= 1'b1;
                    Err1 <= fin_err;
                    Coc1 <= fin_coc;
                    Res1 <= fin_res;
                end else begin
                    Vld0 <= 1'b1;
                    Err0 <= fin_err;
                    Coc0 <= fin_coc;
                    Res0 <= fin_res;
                end
            end
        end
    end

endmodule

// File: tb/tb_div_arbiter_2ch.sv
// Directed testbench for div_arbiter_2ch with a behavioural Start/Done divider.
`timescale 1ns/1ps
module tb_div_arbiter_2ch;

    localparam int W = 32;

    logic         CLK = 1'b0;
    logic         RSTa = 1'b1;
    logic         Req0 = 1'b0;
    logic         Req1 = 1'b0;
    logic [W-1:0] Num0 = '0;
    logic [W-1:0] Den0 = '0;
    logic [W-1:0] Num1 = '0;
    logic [W-1:0] Den1 = '0;
    logic         Ack0, Ack1, Vld0, Vld1, Err0, Err1;
    logic [W-1:0] Coc0, Res0, Coc1, Res1;
    logic         Div_Start;
    logic [W-1:0] Div_Num, Div_Den;
    logic [W-1:0] Div_Coc = '0;
    logic [W-1:0] Div_Res = '0;
    logic         Div_Done;
    logic         model_done = 1'b0;
    logic         inj_done = 1'b0;
    logic         div_hang = 1'b0;
    int           div_lat = 34;

    int n_checks = 0;
    int n_fail = 0;
    int cyc = 0;
    int n_ack0 = 0, n_ack1 = 0, n_vld0 = 0, n_vld1 = 0, n_start = 0;
    int bad_both = 0, bad_same = 0;

    assign Div_Done = model_done | inj_done;

    div_arbiter_2ch #(.tamanyo(W), .TIMEOUT(128)) dut (
        .CLK(CLK), .RSTa(RSTa), .Req0(Req0), .Req1(Req1),
        .Num0(Num0), .Den0(Den0), .Num1(Num1), .Den1(Den1),
        .Ack0(Ack0), .Ack1(Ack1), .Vld0(Vld0), .Vld1(Vld1),
        .Err0(Err0), .Err1(Err1),
        .Coc0(Coc0), .Res0(Res0), .Coc1(Coc1), .Res1(Res1),
        .Div_Start(Div_Start), .Div_Num(Div_Num), .Div_Den(Div_Den),
        .Div_Coc(Div_Coc), .Div_Res(Div_Res), .Div_Done(Div_Done)
    );

    always #5 CLK = ~CLK;

    always @(posedge CLK) cyc <= cyc + 1;

    always @(negedge CLK) begin
        if (Ack0) n_ack0++;
        if (Ack1) n_ack1++;
        if (Vld0) n_vld0++;
        if (Vld1) n_vld1++;
        if (Div_Start) n_start++;
        if (Vld0 && Vld1) bad_both++;
        if ((Ack0 && Vld0) || (Ack1 && Vld1)) bad_same++;
    end

    // Divider: answers div_lat cycles after Start, truncating signed division.
    initial begin : divider_model
        int n, d;
        forever begin
            @(negedge CLK);
            if (Div_Start && !div_hang) begin
                n = $signed(Div_Num);
                d = $signed(Div_Den);
                repeat (div_lat) @(negedge CLK);
                Div_Coc = 32'(n / d);
                Div_Res = 32'(n % d);
                model_done = 1'b1;
                @(negedge CLK);
                model_done = 1'b0;
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic pulse_reset();
        RSTa = 1'b1;
        repeat (2) @(negedge CLK);
        RSTa = 1'b0;
    endtask

    task automatic test_reset();
        RSTa = 1'b1;
        Req0 = 1'b0;
        Req1 = 1'b0;
        repeat (3) @(negedge CLK);
        n_checks++;
        if ({Ack0, Ack1, Vld0, Vld1, Err0, Err1, Div_Start} !== 7'b0) begin
            n_fail++;
            $display("FAIL reset_flags: got %b required 0000000",
                     {Ack0, Ack1, Vld0, Vld1, Err0, Err1, Div_Start});
        end
        n_checks++;
        if ({Coc0, Res0, Coc1, Res1} !== '0) begin
            n_fail++;
            $display("FAIL reset_results: got %h %h %h %h required all 0", Coc0, Res0, Coc1, Res1);
        end
        n_checks++;
        if ({Div_Num, Div_Den} !== '0) begin
            n_fail++;
            $display("FAIL reset_operands: got %h %h required 0 0", Div_Num, Div_Den);
        end
        RSTa = 1'b0;
    endtask

    task automatic test_single();
        int c, s, t, st0;
        st0 = n_start;
        Num0 = 32'd100;
        Den0 = 32'd7;
        Req0 = 1'b1;
        c = cyc;
        t = 0;
        while (!Ack0 && t < 10) begin @(negedge CLK); t++; end
        n_checks++;
        if (Ack0 !== 1'b1 || cyc != c + 1) begin
            n_fail++;
            $display("FAIL single_ack_latency: got ack=%b cycle %0d required ack=1 cycle %0d", Ack0, cyc, c + 1);
        end
        n_checks++;
        if (Div_Start !== 1'b1) begin
            n_fail++;
            $display("FAIL single_start: got %b required 1", Div_Start);
        end
        s = cyc;
        Req0 = 1'b0;
        t = 0;
        while (!Vld0 && t < 100) begin @(negedge CLK); t++; end
        n_checks++;
        if (Vld0 !== 1'b1 || cyc != s + 35) begin
            n_fail++;
            $display("FAIL single_vld_latency: got vld=%b cycle %0d required vld=1 cycle %0d", Vld0, cyc, s + 35);
        end
        n_checks++;
        if (Coc0 !== 32'd14 || Res0 !== 32'd2 || Err0 !== 1'b0) begin
            n_fail++;
            $display("FAIL single_result: got coc=%0d res=%0d err=%b required 14 2 0",
                     $signed(Coc0), $signed(Res0), Err0);
        end
        @(negedge CLK);
        n_checks++;
        if (Vld0 !== 1'b0 || Coc0 !== 32'd14) begin
            n_fail++;
            $display("FAIL single_pulse_hold: got vld=%b coc=%0d required 0 14", Vld0, $signed(Coc0));
        end
        n_checks++;
        if (n_start - st0 != 1) begin
            n_fail++;
            $display("FAIL single_start_count: got %0d required 1", n_start - st0);
        end
    endtask

    task automatic test_round_robin();
        int na, nv, t;
        logic [3:0] gv;
        pulse_reset();
        Num0 = 32'(-9);
        Den0 = 32'd2;
        Num1 = 32'd50;
        Den1 = 32'(-8);
        Req0 = 1'b1;
        Req1 = 1'b1;
        na = 0;
        nv = 0;
        gv = '0;
        t = 0;
        while (nv < 4 && t < 400) begin
            @(negedge CLK);
            t++;
            if (Ack0 || Ack1) begin
                if (na < 4) gv[na] = Ack1;
                na++;
                if (na == 4) begin
                    Req0 = 1'b0;
                    Req1 = 1'b0;
                end
            end
            if (Vld0) begin
                nv++;
                n_checks++;
                if (Coc0 !== 32'(-4) || Res0 !== 32'(-1) || Err0 !== 1'b0) begin
                    n_fail++;
                    $display("FAIL rr_ch0_result: got coc=%0d res=%0d err=%b required -4 -1 0",
                             $signed(Coc0), $signed(Res0), Err0);
                end
            end
            if (Vld1) begin
                nv++;
                n_checks++;
                if (Coc1 !== 32'(-6) || Res1 !== 32'd2 || Err1 !== 1'b0) begin
                    n_fail++;
                    $display("FAIL rr_ch1_result: got coc=%0d res=%0d err=%b required -6 2 0",
                             $signed(Coc1), $signed(Res1), Err1);
                end
            end
        end
        n_checks++;
        if (nv != 4 || na != 4) begin
            n_fail++;
            $display("FAIL rr_counts: got acks=%0d vlds=%0d required 4 4", na, nv);
        end
        n_checks++;
        if (gv !== 4'b1010) begin
            n_fail++;
            $display("FAIL rr_grant_order: got %b required 1010 (bit0 first grant, 1=ch1)", gv);
        end
        n_checks++;
        if (Coc0 !== 32'(-4) || Coc1 !== 32'(-6)) begin
            n_fail++;
            $display("FAIL rr_hold: got coc0=%0d coc1=%0d required -4 -6", $signed(Coc0), $signed(Coc1));
        end
    endtask

    task automatic test_div_zero();
        int c, t, st0;
        st0 = n_start;
        Num1 = 32'd5;
        Den1 = 32'd0;
        Req1 = 1'b1;
        c = cyc;
        t = 0;
        while (!Ack1 && t < 10) begin @(negedge CLK); t++; end
        n_checks++;
        if (Ack1 !== 1'b1 || cyc != c + 1 || Div_Start !== 1'b0) begin
            n_fail++;
            $display("FAIL dz_ack: got ack1=%b cycle %0d start=%b required 1 cycle %0d start=0",
                     Ack1, cyc, Div_Start, c + 1);
        end
        Req1 = 1'b0;
        @(negedge CLK);
        n_checks++;
        if (Vld1 !== 1'b1 || Err1 !== 1'b1) begin
            n_fail++;
            $display("FAIL dz_vld_err: got vld1=%b err1=%b required 1 1", Vld1, Err1);
        end
        n_checks++;
        if (Coc1 !== 32'hFFFFFFFF || Res1 !== 32'd5) begin
            n_fail++;
            $display("FAIL dz_result: got coc1=%h res1=%h required ffffffff 00000005", Coc1, Res1);
        end
        @(negedge CLK);
        n_checks++;
        if (n_start != st0) begin
            n_fail++;
            $display("FAIL dz_no_start: got %0d starts required 0", n_start - st0);
        end
    endtask

    task automatic test_timeout();
        int s, t, v0, a0;
        div_hang = 1'b1;
        Num0 = 32'd77;
        Den0 = 32'd3;
        Req0 = 1'b1;
        t = 0;
        while (!Ack0 && t < 10) begin @(negedge CLK); t++; end
        s = cyc;
        Req0 = 1'b0;
        t = 0;
        while (!Vld0 && t < 200) begin @(negedge CLK); t++; end
        n_checks++;
        if (Vld0 !== 1'b1 || cyc != s + 128) begin
            n_fail++;
            $display("FAIL tmo_latency: got vld0=%b cycle %0d required vld0=1 cycle %0d", Vld0, cyc, s + 128);
        end
        n_checks++;
        if (Err0 !== 1'b1 || Coc0 !== '0 || Res0 !== '0) begin
            n_fail++;
            $display("FAIL tmo_result: got err=%b coc=%h res=%h required 1 0 0", Err0, Coc0, Res0);
        end
        @(negedge CLK);
        v0 = n_vld0;
        a0 = n_ack0 + n_ack1;
        inj_done = 1'b1;
        @(negedge CLK);
        inj_done = 1'b0;
        repeat (3) @(negedge CLK);
        n_checks++;
        if (n_vld0 != v0 || n_ack0 + n_ack1 != a0) begin
            n_fail++;
            $display("FAIL tmo_late_done: got %0d extra vld %0d extra ack required 0 0",
                     n_vld0 - v0, n_ack0 + n_ack1 - a0);
        end
        div_hang = 1'b0;
        Num0 = 32'd20;
        Den0 = 32'(-6);
        Req0 = 1'b1;
        t = 0;
        while (!Ack0 && t < 10) begin @(negedge CLK); t++; end
        Req0 = 1'b0;
        t = 0;
        while (!Vld0 && t < 100) begin @(negedge CLK); t++; end
        n_checks++;
        if (Vld0 !== 1'b1 || Coc0 !== 32'(-3) || Res0 !== 32'd2 || Err0 !== 1'b0) begin
            n_fail++;
            $display("FAIL tmo_recover: got vld=%b coc=%0d res=%0d err=%b required 1 -3 2 0",
                     Vld0, $signed(Coc0), $signed(Res0), Err0);
        end
    endtask

    task automatic test_reset_wait();
        int t, v, nv;
        div_hang = 1'b1;
        Num0 = 32'd9;
        Den0 = 32'd4;
        Req0 = 1'b1;
        t = 0;
        while (!Ack0 && t < 10) begin @(negedge CLK); t++; end
        Req0 = 1'b0;
        repeat (5) @(negedge CLK);
        v = n_vld0 + n_vld1;
        RSTa = 1'b1;
        Num1 = 32'(-7);
        Den1 = 32'(-2);
        Req0 = 1'b1;
        Req1 = 1'b1;
        @(negedge CLK);
        n_checks++;
        if ({Ack0, Ack1, Vld0, Vld1, Err0, Err1, Div_Start} !== 7'b0 ||
            {Coc0, Res0, Coc1, Res1, Div_Num, Div_Den} !== '0) begin
            n_fail++;
            $display("FAIL rstw_outputs: got flags=%b coc0=%h div_num=%h required all 0",
                     {Ack0, Ack1, Vld0, Vld1, Err0, Err1, Div_Start}, Coc0, Div_Num);
        end
        n_checks++;
        if (n_vld0 + n_vld1 != v) begin
            n_fail++;
            $display("FAIL rstw_no_vld: got %0d vld required 0", n_vld0 + n_vld1 - v);
        end
        RSTa = 1'b0;
        div_hang = 1'b0;
        t = 0;
        while (!(Ack0 || Ack1) && t < 10) begin @(negedge CLK); t++; end
        n_checks++;
        if (Ack0 !== 1'b1 || Ack1 !== 1'b0) begin
            n_fail++;
            $display("FAIL rstw_first_grant: got ack0=%b ack1=%b required 1 0", Ack0, Ack1);
        end
        Req0 = 1'b0;
        nv = 0;
        t = 0;
        while (nv < 2 && t < 300) begin
            @(negedge CLK);
            t++;
            if (Ack1) Req1 = 1'b0;
            if (Vld0) begin
                nv++;
                n_checks++;
                if (Coc0 !== 32'd2 || Res0 !== 32'd1 || Err0 !== 1'b0) begin
                    n_fail++;
                    $display("FAIL rstw_ch0_result: got coc=%0d res=%0d err=%b required 2 1 0",
                             $signed(Coc0), $signed(Res0), Err0);
                end
            end
            if (Vld1) begin
                nv++;
                n_checks++;
                if (Coc1 !== 32'd3 || Res1 !== 32'(-1) || Err1 !== 1'b0) begin
                    n_fail++;
                    $display("FAIL rstw_ch1_result: got coc=%0d res=%0d err=%b required 3 -1 0",
                             $signed(Coc1), $signed(Res1), Err1);
                end
            end
        end
        n_checks++;
        if (nv != 2) begin
            n_fail++;
            $display("FAIL rstw_vld_count: got %0d required 2", nv);
        end
        Req1 = 1'b0;
    endtask

    task automatic test_spurious_done();
        int a, v;
        repeat (2) @(negedge CLK);
        a = n_ack0 + n_ack1;
        v = n_vld0 + n_vld1;
        inj_done = 1'b1;
        @(negedge CLK);
        inj_done = 1'b0;
        repeat (3) @(negedge CLK);
        n_checks++;
        if (n_vld0 + n_vld1 != v || n_ack0 + n_ack1 != a || Div_Start !== 1'b0) begin
            n_fail++;
            $display("FAIL spurious_done_activity: got %0d vld %0d ack start=%b required 0 0 0",
                     n_vld0 + n_vld1 - v, n_ack0 + n_ack1 - a, Div_Start);
        end
        n_checks++;
        if (Coc0 !== 32'd2 || Res0 !== 32'd1 || Coc1 !== 32'd3 || Res1 !== 32'(-1)) begin
            n_fail++;
            $display("FAIL spurious_done_hold: got %0d %0d %0d %0d required 2 1 3 -1",
                     $signed(Coc0), $signed(Res0), $signed(Coc1), $signed(Res1));
        end
        n_checks++;
        if (bad_both != 0 || bad_same != 0) begin
            n_fail++;
            $display("FAIL pulse_exclusion: got both_vld=%0d ack_vld_same=%0d required 0 0",
                     bad_both, bad_same);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_div_zero();
        test_timeout();
        test_reset_wait();
        test_spurious_done();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
